viterbi_stream_decoder: RTL

//  Streaming hard-decision Viterbi decoder, rate 1/2, constraint length K: parametrised successor of the fixed 4-state block.
//  - Accepts one 2-bit code symbol per handshake.
//  - Add-compare-select over 2^(K-1) states; register-exchange survivor memory TB_DEPTH deep.
//  - Emits one decoded bit per symbol with ready/valid; flushes buffered bits at frame end.
//  - Sits between the demodulator slicer and the frame deframer.

---
 rtl/viterbi_pkg.sv | 43 ++++
 rtl/viterbi_acs_cell.sv | 27 ++
 rtl/viterbi_stream_decoder.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/viterbi_pkg.sv
// Shared types and elaboration-time helpers for the streaming Viterbi decoder.
package viterbi_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} vit_state_e;

  function automatic int ns_of(input int k);
    return 1 << (k - 1);
  endfunction

  function automatic int sw_of(input int k);
    return k - 1;
  endfunction

  function automatic int pm_init(input int w);
    return 1 << (w - 1);
  endfunction

  // Generator parameters are written as octal digits, e.g. 23 means 'o23.
  function automatic int oct_to_taps(input int oct);
    int v;
    int taps;
    v = oct;
    taps = 0;
    for (int i = 0; i < 4; i++) begin
      taps = taps | ((v % 10) << (3 * i));
      v = v / 10;
    end
    return taps;
  endfunction

  // Encoder register is {input bit, state}; returns {c0, c1}.
  function automatic logic [1:0] exp_bits(input int state, input logic b, input int k,
                                          input int t0, input int t1);
    int r;
    r = (int'(b) << (k - 1)) | state;
    return {^(r & t0), ^(r & t1)};
  endfunction

  function automatic logic [1:0] hamming2(input logic [1:0] x);
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

endpackage

// File: rtl/viterbi_acs_cell.sv
// One add-compare-select cell: picks the cheaper of two predecessors, ties to predecessor a.
module viterbi_acs_cell #(
  parameter int PM_WIDTH = 6,
  parameter int TB_DEPTH = 8
) (
  input  logic [PM_WIDTH-1:0] pm_a,
  input  logic [PM_WIDTH-1:0] pm_b,
  input  logic [1:0]          bm_a,
  input  logic [1:0]          bm_b,
  input  logic [TB_DEPTH-1:0] surv_a,
  input  logic [TB_DEPTH-1:0] surv_b,
  input  logic                dec_bit,
  output logic [PM_WIDTH-1:0] pm_out,
  output logic [TB_DEPTH-1:0] surv_out
);
  logic [PM_WIDTH-1:0] cand_a;
  logic [PM_WIDTH-1:0] cand_b;
  logic                pick_b;

  always_comb begin
    cand_a   = pm_a + PM_WIDTH'(bm_a);
    cand_b   = pm_b + PM_WIDTH'(bm_b);
    pick_b   = cand_b < cand_a;
    pm_out   = pick_b ? cand_b : cand_a;
    surv_out = {(pick_b ? surv_b[TB_DEPTH-2:0] : surv_a[TB_DEPTH-2:0]), dec_bit};
  end
endmodule

// File: rtl/viterbi_stream_decoder.sv
// Streaming rate-1/2 hard-decision Viterbi decoder, register-exchange survivors.
// VITERBI_TERM_EN: zero-tail frames, decode from state 0, tail bits not emitted.
//   state | meaning
//   IDLE  | waiting for a symbol with in_sof; others are dropped
//   RUN   | ACS per symbol, one bit out per symbol once survivors are full
//   FLUSH | shifting out buffered bits of the latched survivor
module viterbi_stream_decoder
  import viterbi_pkg::*;
#(
  parameter int K        = 3,
  parameter int G0       = 7,
  parameter int G1       = 5,
  parameter int PM_WIDTH = 6,
  parameter int TB_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_sym,
  input  logic       in_sof,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_bit,
  output logic       out_last
);
  localparam int NS = ns_of(K);
  localparam int SW = sw_of(K);
  localparam int T0 = oct_to_taps(G0);
  localparam int T1 = oct_to_taps(G1);
  localparam int CW = $clog2(TB_DEPTH + K);
  localparam logic [PM_WIDTH-1:0] PM_INIT = PM_WIDTH'(pm_init(PM_WIDTH));
`ifdef VITERBI_TERM_EN
  localparam bit TERM_EN = 1'b1;
`else
  localparam bit TERM_EN = 1'b0;
`endif

  vit_state_e                  state_q, state_d;
  logic [NS-1:0][PM_WIDTH-1:0] pm_q, pm_d, pm_src, acs_pm, pm_norm;
  logic [NS-1:0][TB_DEPTH-1:0] surv_q, surv_d, surv_src, acs_surv;
  logic [CW-1:0]               fill_q, fill_d, flush_cnt_q, flush_cnt_d;
  logic [TB_DEPTH-1:0]         flush_sr_q, flush_sr_d;
  logic                        out_valid_q, out_valid_d, out_bit_q, out_bit_d;
  logic                        out_last_q, out_last_d;

  logic                        out_free, accept, init, do_acs, emit;
  logic [PM_WIDTH-1:0]         min_pm;
  logic [SW-1:0]               best_idx;
  logic [CW-1:0]               fill_base, rem, flush_n;
  logic [TB_DEPTH-1:0]         sel_surv;

  assign out_free  = !out_valid_q || out_ready;
  assign in_ready  = (state_q != FLUSH) && out_free;
  assign accept    = in_valid && in_ready;
  assign init      = accept && in_sof;
  assign do_acs    = accept && (in_sof || (state_q == RUN));
  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign out_last  = out_last_q;

  // A new frame starts from the all-zero encoder state with fresh survivors.
  always_comb begin
    for (int i = 0; i < NS; i++) begin
      pm_src[i]   = init ? ((i == 0) ? '0 : PM_INIT) : pm_q[i];
      surv_src[i] = init ? '0 : surv_q[i];
    end
  end

  for (genvar n = 0; n < NS; n++) begin : g_acs
    localparam int PA = (n * 2) % NS;
    localparam int PB = PA + 1;
    localparam logic U = 1'(n >> (K - 2));
    localparam logic [1:0] EA = exp_bits(PA, U, K, T0, T1);
    localparam logic [1:0] EB = exp_bits(PB, U, K, T0, T1);
    logic [1:0] bm_a, bm_b;
    assign bm_a = hamming2(in_sym ^ EA);
    assign bm_b = hamming2(in_sym ^ EB);
    viterbi_acs_cell #(.PM_WIDTH(PM_WIDTH), .TB_DEPTH(TB_DEPTH)) u_cell (
      .pm_a    (pm_src[PA]),
      .pm_b    (pm_src[PB]),
      .bm_a    (bm_a),
      .bm_b    (bm_b),
      .surv_a  (surv_src[PA]),
      .surv_b  (surv_src[PB]),
      .dec_bit (U),
      .pm_out  (acs_pm[n]),
      .surv_out(acs_surv[n])
    );
  end

  always_comb begin
    min_pm   = acs_pm[0];
    best_idx = '0;
    for (int i = 1; i < NS; i++) begin
      if (acs_pm[i] < min_pm) begin
        min_pm   = acs_pm[i];
        best_idx = SW'(i);
      end
    end
    for (int i = 0; i < NS; i++) pm_norm[i] = acs_pm[i] - min_pm;
  end

  always_comb begin
    state_d     = state_q;
    pm_d        = pm_q;
    surv_d      = surv_q;
    fill_d      = fill_q;
    flush_sr_d  = flush_sr_q;
    flush_cnt_d = flush_cnt_q;
    out_valid_d = out_valid_q && !out_ready;
    out_bit_d   = out_bit_q;
    out_last_d  = out_last_q && !(out_valid_q && out_ready);

    fill_base = init ? '0 : fill_q;
    emit      = fill_base >= CW'(TB_DEPTH - 1);
    // Bits held in the survivor that have not been emitted yet, after this symbol.
    rem       = emit ? CW'(TB_DEPTH - 1) : fill_base + CW'(1);
    if (TERM_EN) flush_n = (rem > CW'(K - 1)) ? rem - CW'(K - 1) : '0;
    else         flush_n = rem;
    sel_surv  = TERM_EN ? acs_surv[0] : acs_surv[best_idx];

    if (do_acs) begin
      pm_d   = pm_norm;
      surv_d = acs_surv;
      fill_d = (fill_base == CW'(TB_DEPTH)) ? fill_base : fill_base + CW'(1);
      if (emit) begin
        out_valid_d = 1'b1;
        out_bit_d   = sel_surv[TB_DEPTH-1];
        out_last_d  = in_last && (flush_n == '0);
      end
      if (in_last) begin
        flush_sr_d  = sel_surv << (CW'(TB_DEPTH) - rem);
        flush_cnt_d = flush_n;
        if (flush_n == '0) begin
          state_d = IDLE;
          fill_d  = '0;
        end else begin
          state_d = FLUSH;
        end
      end else begin
        state_d = RUN;
      end
    end else if ((state_q == FLUSH) && out_free) begin
      out_valid_d = 1'b1;
      out_bit_d   = flush_sr_q[TB_DEPTH-1];
      out_last_d  = (flush_cnt_q == CW'(1));
      flush_sr_d  = flush_sr_q << 1;
      flush_cnt_d = flush_cnt_q - CW'(1);
      if (flush_cnt_q == CW'(1)) begin
        state_d = IDLE;
        fill_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pm_q        <= '0;
      surv_q      <= '0;
      fill_q      <= '0;
      flush_sr_q  <= '0;
      flush_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pm_q        <= pm_d;
      surv_q      <= surv_d;
      fill_q      <= fill_d;
      flush_sr_q  <= flush_sr_d;
      flush_cnt_q <= flush_cnt_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_last_q  <= out_last_d;
    end
  end
endmodule
